// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the hazard controller and its CSR-facing stall counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Register-file address width (x0..x31).
    localparam int REG_ADDR_W  = 5;
    // CSR datapath width; the stall counter is read through a CSR, so it matches.
    localparam int CSR_W       = 64;
    localparam int STALL_CNT_W = CSR_W;

    // Outstanding-memory-transaction tracker states.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IM   = 2'd1,
        WAIT_DM   = 2'd2,
        WAIT_BOTH = 2'd3
    } hz_state_e;

    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller drives stage enables, the pipeline obeys them.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] ID_rs1_addr;
    logic [REG_ADDR_W-1:0] ID_rs2_addr;
    logic                  ID_rs1_used;
    logic                  ID_rs2_used;
    logic [REG_ADDR_W-1:0] EXE_rd_addr;
    logic                  EXE_MemRead;
    logic [1:0]            PCSrc;
    logic                  IM_req;
    logic                  DM_req;
    logic                  IM_done;
    logic                  DM_done;

    logic                  PC_write;
    logic                  IF_ID_write;
    logic                  IF_ID_flush;
    logic                  ID_EXE_flush;
    logic                  lw_use;
    logic                  Hazardstall_flag;
    stall_cnt_t            stall_cycles;
    logic                  spurious_done;

    // Pipeline side: supplies hazard sources, consumes enables/flushes.
    modport master (
        output ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
        output EXE_rd_addr, EXE_MemRead, PCSrc,
        output IM_req, DM_req, IM_done, DM_done,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush,
        input  lw_use, Hazardstall_flag, stall_cycles, spurious_done
    );

    // Hazard controller side.
    modport slave (
        input  ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
        input  EXE_rd_addr, EXE_MemRead, PCSrc,
        input  IM_req, DM_req, IM_done, DM_done,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush,
        output lw_use, Hazardstall_flag, stall_cycles, spurious_done
    );

endinterface

// File: rtl/hazard_lw_detect.sv
// Load-use compare between the load in EXE and the sources of the instruction in ID.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with stall/branch priority.
module hazard_lw_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  mem_read,
    output logic                  hit
);

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    always_comb begin
        hit = mem_read && (rd_addr != '0) &&
              ((rs1_used && (rs1_addr == rd_addr)) ||
               (rs2_used && (rs2_addr == rd_addr)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory-wait freeze, branch flush, load-use bubble, stall counter.
// Latency: Hazardstall_flag is registered (1 cycle after req); enables/flushes are combinational.
// Backpressure: freezes the whole pipeline while any IM/DM transaction is outstanding.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    hz_state_e  state;
    hz_state_e  state_nxt;
    logic       stall_q;
    stall_cnt_t stall_cnt;
    logic       spur_q;
    logic       spur_evt;
    logic       lw_hit;
    logic       stall_eff;
    logic       branch;

    hazard_lw_detect u_lw_detect (
        .rs1_addr (bus.ID_rs1_addr),
        .rs2_addr (bus.ID_rs2_addr),
        .rs1_used (bus.ID_rs1_used),
        .rs2_used (bus.ID_rs2_used),
        .rd_addr  (bus.EXE_rd_addr),
        .mem_read (bus.EXE_MemRead),
        .hit      (lw_hit)
    );

    // FSM state register; the stall flag is registered alongside it so it tracks state != RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            stall_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            stall_q <= (state_nxt != RUN);
        end
    end

    // Next-state: requests only accepted in RUN; done pulses retire their own pending side.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (bus.IM_req && bus.DM_req) state_nxt = WAIT_BOTH;
                else if (bus.IM_req)          state_nxt = WAIT_IM;
                else if (bus.DM_req)          state_nxt = WAIT_DM;
            end
            WAIT_BOTH: begin
                if (bus.IM_done && bus.DM_done) state_nxt = RUN;
                else if (bus.IM_done)           state_nxt = WAIT_DM;
                else if (bus.DM_done)           state_nxt = WAIT_IM;
            end
            WAIT_IM: if (bus.IM_done) state_nxt = RUN;
            WAIT_DM: if (bus.DM_done) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // A done with nothing outstanding on that side is a protocol error, not a transition.
    always_comb begin
        spur_evt = (bus.IM_done && !((state == WAIT_IM) || (state == WAIT_BOTH))) ||
                   (bus.DM_done && !((state == WAIT_DM) || (state == WAIT_BOTH)));
    end

    // Stall counter wraps freely; spurious-done flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            spur_q    <= 1'b0;
        end else begin
            if (stall_q)  stall_cnt <= stall_cnt + stall_cnt_t'(1);
            if (spur_evt) spur_q    <= 1'b1;
        end
    end

    // Output decode, priority: memory stall > branch > load-use > normal.
    // Reset masks the stall so the pipeline sees the post-reset (RUN) behaviour immediately.
    always_comb begin
        stall_eff        = stall_q && !rst;
        branch           = (bus.PCSrc != 2'b00);
        bus.lw_use       = lw_hit && !stall_eff && !branch;
        bus.PC_write     = 1'b1;
        bus.IF_ID_write  = 1'b1;
        bus.IF_ID_flush  = 1'b0;
        bus.ID_EXE_flush = 1'b0;
        if (stall_eff) begin
            bus.PC_write    = 1'b0;
            bus.IF_ID_write = 1'b0;
        end else if (branch) begin
            bus.IF_ID_flush  = 1'b1;
            bus.ID_EXE_flush = 1'b1;
        end else if (bus.lw_use) begin
            bus.PC_write     = 1'b0;
            bus.IF_ID_write  = 1'b0;
            bus.ID_EXE_flush = 1'b1;
        end
    end

    assign bus.Hazardstall_flag = stall_q;
    assign bus.stall_cycles     = stall_cnt;
    assign bus.spurious_done    = spur_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
// Latency: driver applies one vector per cycle just after posedge; monitor checks on negedge.
// Backpressure: n/a.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic [6:0]  sig;
        logic [63:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, lw_use, Hazardstall_flag, spurious_done}
    localparam logic [6:0] NORM = 7'b1100000;
    localparam logic [6:0] STL  = 7'b0000010;
    localparam logic [6:0] BR   = 7'b1111000;
    localparam logic [6:0] LW   = 7'b0001100;
    localparam logic [6:0] SP   = 7'b0000001;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic cyc(input string name, input bit chk, input bit r,
                       input bit iq, input bit dq, input bit id, input bit dd,
                       input logic [1:0] pc,
                       input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd, input bit mr,
                       input logic [6:0] sig, input logic [63:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.IM_req      = iq;
        bus.DM_req      = dq;
        bus.IM_done     = id;
        bus.DM_done     = dd;
        bus.PCSrc       = pc;
        bus.ID_rs1_addr = rs1;
        bus.ID_rs1_used = u1;
        bus.ID_rs2_addr = rs2;
        bus.ID_rs2_used = u2;
        bus.EXE_rd_addr = rd;
        bus.EXE_MemRead = mr;
        if (chk) begin
            e.name = name;
            e.sig  = sig;
            e.cnt  = cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input string name, input logic [6:0] sig, input logic [63:0] cnt);
        cyc(name, 1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, sig, cnt);
    endtask

    task automatic do_reset(input string name, input logic [6:0] sig, input logic [63:0] cnt);
        cyc(name, 1'b1, 1'b1, 0, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, sig, cnt);
    endtask

    // Monitor: outputs are valid every cycle, so each queued expectation is checked on the next negedge.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EXE_flush,
                       bus.lw_use, bus.Hazardstall_flag, bus.spurious_done};
                compared++;
                if (act !== e.sig || bus.stall_cycles !== e.cnt) begin
                    mismatched++;
                    $display("FAIL %s: got sig=%b cnt=%0h, want sig=%b cnt=%0h",
                             e.name, act, bus.stall_cycles, e.sig, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IM_req = 0; bus.DM_req = 0; bus.IM_done = 0; bus.DM_done = 0;
        bus.PCSrc = 2'b00; bus.ID_rs1_addr = '0; bus.ID_rs2_addr = '0;
        bus.ID_rs1_used = 0; bus.ID_rs2_used = 0; bus.EXE_rd_addr = '0; bus.EXE_MemRead = 0;

        // Reset state
        cyc("rst0", 1'b0, 1'b1, 0, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, 64'd0);
        do_reset("rst1", NORM, 64'd0);

        // IM wait: req cycle 0, done cycle 3
        cyc("a0_imreq", 1, 0, 1, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, 64'd0);
        idle("a1_wait", STL, 64'd0);
        idle("a2_wait", STL, 64'd1);
        cyc("a3_imdone", 1, 0, 0, 0, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, STL, 64'd2);
        idle("a4_run", NORM, 64'd3);
        do_reset("a_rst", NORM, 64'd3);

        // Both outstanding: DM done at 2, IM done at 5, extra IM_req at 4 ignored
        cyc("b0_both", 1, 0, 1, 1, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, 64'd0);
        idle("b1_wboth", STL, 64'd0);
        cyc("b2_dmdone", 1, 0, 0, 0, 0, 1, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, STL, 64'd1);
        idle("b3_wim", STL, 64'd2);
        cyc("b4_req_ign", 1, 0, 1, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, STL, 64'd3);
        cyc("b5_imdone", 1, 0, 0, 0, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, STL, 64'd4);
        idle("b6_run", NORM, 64'd5);
        do_reset("b_rst", NORM, 64'd5);

        // Load-use detection
        cyc("c0_lw_rs2", 1, 0, 0, 0, 0, 0, 2'b00, 5'd0, 0, 5'd5, 1, 5'd5, 1, LW, 64'd0);
        cyc("c1_lw_x0", 1, 0, 0, 0, 0, 0, 2'b00, 5'd0, 1, 5'd0, 1, 5'd0, 1, NORM, 64'd0);
        cyc("c2_unused", 1, 0, 0, 0, 0, 0, 2'b00, 5'd5, 0, 5'd6, 1, 5'd5, 1, NORM, 64'd0);
        cyc("c3_noload", 1, 0, 0, 0, 0, 0, 2'b00, 5'd7, 1, 5'd0, 0, 5'd7, 0, NORM, 64'd0);
        cyc("c4_lw_rs1", 1, 0, 0, 0, 0, 0, 2'b00, 5'd9, 1, 5'd3, 1, 5'd9, 1, LW, 64'd0);

        // Branch beats load-use; branch during stall flushes on first RUN cycle
        cyc("d0_br_lw", 1, 0, 0, 0, 0, 0, 2'b01, 5'd0, 0, 5'd5, 1, 5'd5, 1, BR, 64'd0);
        cyc("d1_br", 1, 0, 0, 0, 0, 0, 2'b10, 5'd0, 0, 5'd0, 0, 5'd0, 0, BR, 64'd0);
        cyc("d2_imreq", 1, 0, 1, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, 64'd0);
        cyc("d3_stl_br", 1, 0, 0, 0, 0, 0, 2'b01, 5'd0, 0, 5'd5, 1, 5'd5, 1, STL, 64'd0);
        cyc("d4_stl_done", 1, 0, 0, 0, 1, 0, 2'b01, 5'd0, 0, 5'd5, 1, 5'd5, 1, STL, 64'd1);
        cyc("d5_br_run", 1, 0, 0, 0, 0, 0, 2'b01, 5'd0, 0, 5'd5, 1, 5'd5, 1, BR, 64'd2);
        idle("d6_norm", NORM, 64'd2);
        do_reset("d_rst", NORM, 64'd2);

        // Spurious done and reset mid-WAIT_DM
        cyc("e0_im_spur", 1, 0, 0, 0, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, 64'd0);
        idle("e1_sticky", NORM | SP, 64'd0);
        cyc("e2_dmreq", 1, 0, 0, 1, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM | SP, 64'd0);
        cyc("e3_im_in_wdm", 1, 0, 0, 0, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, STL | SP, 64'd0);
        cyc("e4_rst_wdm", 1, 1, 0, 0, 0, 1, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, 7'b1100011, 64'd1);
        idle("e5_after_rst", NORM, 64'd0);
        cyc("e6_dm_spur", 1, 0, 0, 0, 0, 1, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, 64'd0);
        idle("e7_sticky", NORM | SP, 64'd0);
        do_reset("e_rst", NORM | SP, 64'd0);
        idle("e8_clear", NORM, 64'd0);

        // Counter wrap from all-ones
        cyc("f0_imreq", 1, 0, 1, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, NORM, ONES);
        force dut.stall_cnt = ONES;
        cyc("f1_stall", 1, 0, 0, 0, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0, 0, STL, ONES);
        release dut.stall_cnt;
        idle("f2_wrap", NORM, 64'd0);

        begin
            int waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            #1;
            if (exp_q.size() > 0) begin
                mismatched++;
                $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ID_rs1_addr, ID_rs2_addr  input  5  source registers of the instruction in ID.
REQ-004 SHALL have ports: ID_rs1_used, ID_rs2_used  input  1  ID instruction reads that source.
REQ-005 SHALL have ports: EXE_rd_addr  input  5; EXE_MemRead  input  1  load in EXE.
REQ-006 SHALL have port: PCSrc  input  2  branch/jump taken in EXE when nonzero, same encoding as the CSR unit.
REQ-007 SHALL have ports: IM_req, DM_req  input  1  single-cycle pulse when a memory transaction is issued; IM_done, DM_done  input  1  single-cycle completion pulses.
REQ-008 SHALL have outputs: PC_write, IF_ID_write  1  stage enables; IF_ID_flush, ID_EXE_flush  1  bubble inserts.
REQ-009 SHALL have outputs: lw_use, Hazardstall_flag  1  consumed by the CSR unit; stall_cycles  64  count of stalled cycles; spurious_done  1  sticky error flag.

Function
REQ-010 SHALL implement FSM states RUN, WAIT_IM, WAIT_DM, WAIT_BOTH.
REQ-011 In RUN: IM_req&DM_req -> WAIT_BOTH; IM_req only -> WAIT_IM; DM_req only -> WAIT_DM; none -> RUN.
REQ-012 In WAIT_BOTH: both done -> RUN; IM_done only -> WAIT_DM; DM_done only -> WAIT_IM; none -> stay.
REQ-013 In WAIT_IM: IM_done -> RUN; in WAIT_DM: DM_done -> RUN. Requests during any WAIT state are ignored.
REQ-014 A done pulse with no matching pending transaction (e.g. IM_done in RUN or WAIT_DM) SHALL not change state and SHALL set spurious_done, which holds until reset.
REQ-015 Hazardstall_flag SHALL be registered: 1 exactly when state != RUN.
REQ-016 lw_use SHALL be combinational: EXE_MemRead & EXE_rd_addr!=0 & ((ID_rs1_used & rs1==rd) | (ID_rs2_used & rs2==rd)), forced 0 when Hazardstall_flag=1 or PCSrc!=0.
REQ-017 Priority per cycle: Hazardstall_flag > branch (PCSrc!=0) > lw_use > normal.
REQ-018 Hazardstall_flag=1: PC_write=0, IF_ID_write=0, both flushes 0 (whole pipeline frozen).
REQ-019 Branch (not stalled): PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EXE_flush=1 for that cycle.
REQ-020 A PCSrc!=0 seen while stalled SHALL produce the flushes on the first RUN cycle (PCSrc assumed held by the frozen EXE stage); no separate latch.
REQ-021 lw_use: PC_write=0, IF_ID_write=0, ID_EXE_flush=1, IF_ID_flush=0; exactly one bubble per load-use pair.
REQ-022 Normal: PC_write=1, IF_ID_write=1, flushes 0.
REQ-023 stall_cycles SHALL increment by 1 each cycle Hazardstall_flag=1, wrapping modulo 2^64 without saturation.

Reset
REQ-024 On rst sampled high: state=RUN, Hazardstall_flag=0, stall_cycles=0, spurious_done=0; pending transactions discarded, including mid-WAIT.
REQ-025 During rst, combinational outputs follow REQ-016..022 with Hazardstall_flag=0.
REQ-026 Done pulses coincident with rst SHALL be ignored.

Structure
REQ-027 FSM state enum and the 64-bit counter width SHALL live in the shared package alongside the CSR width macro; register-address width reuses the existing define.
REQ-028 One sub-module, hazard_lw_detect (combinational load-use compare), is natural; FSM and counter stay in hazard_ctrl.

Verification
REQ-029 IM_req at cycle 0, IM_done at cycle 3 -> Hazardstall_flag 1 in cycles 1-3, 0 in cycle 4; stall_cycles=3.
REQ-030 IM_req&DM_req at cycle 0, DM_done at 2, IM_done at 5 -> WAIT_BOTH, WAIT_IM at 3, RUN at 6; stall_cycles=5.
REQ-031 EXE load rd=x5, ID rs2=x5 used -> lw_use=1, PC_write=0, ID_EXE_flush=1 one cycle; with rd=x0 -> lw_use=0.
REQ-032 PCSrc=2'b01 with load-use match in same cycle -> IF_ID_flush=ID_EXE_flush=1, lw_use=0.
REQ-033 IM_done in RUN -> state RUN, spurious_done=1 until rst; rst during WAIT_DM -> RUN, stall_cycles=0 next cycle.
REQ-034 Preload stall_cycles to 2^64-1 via force, one stall cycle -> stall_cycles=0.
